// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline: instruction field positions,
// opcode/funct values, ALU and write-back source encodings, control bundle.
package pipe_pkg;

  localparam int unsigned OP_LO  = 26;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned SH_LO  = 6;
  localparam int unsigned FN_LO  = 0;
  localparam int unsigned IMM_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI,
    ALU_BEQ,
    ALU_BNE
  } alu_code_t;

  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_PC4 = 2'd2
  } mem_to_reg_t;

  typedef struct packed {
    logic       RegWrite;
    logic       RegDst;
    logic       MemRead;
    logic       MemWrite;
    logic       ALUSrcB;
    logic       Branch;
    logic [1:0] MemtoReg;
    logic [3:0] ALUCode;
  } ctrl_t;

endpackage

// File: rtl/CtrlUnit.sv
// Main control decoder: opcode/funct to datapath control bits.
module CtrlUnit
  import pipe_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUSrcB,
  output logic       Branch,
  output logic [1:0] MemtoReg,
  output logic [3:0] ALUCode
);

  ctrl_t c;

  // Decode one instruction into its control bundle; unknown opcodes decode to a no-op.
  always_comb begin
    c = '0;
    unique case (op)
      OP_RTYPE: begin
        c.RegWrite = 1'b1;
        c.RegDst   = 1'b1;
        unique case (funct)
          FN_ADD, FN_ADDU: c.ALUCode = ALU_ADD;
          FN_SUB, FN_SUBU: c.ALUCode = ALU_SUB;
          FN_AND:          c.ALUCode = ALU_AND;
          FN_OR:           c.ALUCode = ALU_OR;
          FN_XOR:          c.ALUCode = ALU_XOR;
          FN_NOR:          c.ALUCode = ALU_NOR;
          FN_SLT:          c.ALUCode = ALU_SLT;
          FN_SLL:          c.ALUCode = ALU_SLL;
          FN_SRL:          c.ALUCode = ALU_SRL;
          FN_SRA:          c.ALUCode = ALU_SRA;
          default:         c.RegWrite = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin c.RegWrite = 1'b1; c.ALUSrcB = 1'b1; c.ALUCode = ALU_ADD; end
      OP_SLTI: begin c.RegWrite = 1'b1; c.ALUSrcB = 1'b1; c.ALUCode = ALU_SLT; end
      OP_ANDI: begin c.RegWrite = 1'b1; c.ALUSrcB = 1'b1; c.ALUCode = ALU_AND; end
      OP_ORI:  begin c.RegWrite = 1'b1; c.ALUSrcB = 1'b1; c.ALUCode = ALU_OR;  end
      OP_XORI: begin c.RegWrite = 1'b1; c.ALUSrcB = 1'b1; c.ALUCode = ALU_XOR; end
      OP_LUI:  begin c.RegWrite = 1'b1; c.ALUSrcB = 1'b1; c.ALUCode = ALU_LUI; end
      OP_LW: begin
        c.RegWrite = 1'b1;
        c.MemRead  = 1'b1;
        c.ALUSrcB  = 1'b1;
        c.MemtoReg = MTR_MEM;
        c.ALUCode  = ALU_ADD;
      end
      OP_SW:  begin c.MemWrite = 1'b1; c.ALUSrcB = 1'b1; c.ALUCode = ALU_ADD; end
      OP_BEQ: begin c.Branch = 1'b1; c.ALUCode = ALU_BEQ; end
      OP_BNE: begin c.Branch = 1'b1; c.ALUCode = ALU_BNE; end
      default: c = '0;
    endcase
  end

  assign RegWrite = c.RegWrite;
  assign RegDst   = c.RegDst;
  assign MemRead  = c.MemRead;
  assign MemWrite = c.MemWrite;
  assign ALUSrcB  = c.ALUSrcB;
  assign Branch   = c.Branch;
  assign MemtoReg = c.MemtoReg;
  assign ALUCode  = c.ALUCode;

endmodule

// File: rtl/regfile_bypass.sv
// Register file with two read ports and write-through bypass from WB.
// Register 0 is hard-wired to zero.
module regfile_bypass #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned REG_N  = 32,
  localparam int unsigned RA_W   = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [RA_W-1:0]   raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [REG_N];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  // Storage: cleared on reset, written on the rising edge for non-zero addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_N; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports: same-cycle WB data wins over stored data, r0 always reads zero.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (wr_en && (waddr == raddr_a))  rdata_a = wdata;
    else if (raddr_a != '0)           rdata_a = mem[raddr_a];
    if (wr_en && (waddr == raddr_b))  rdata_b = wdata;
    else if (raddr_b != '0)           rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: instruction decode, register read with WB bypass,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage_pipe
  import pipe_pkg::*;
#(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned REG_N  = 32,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned RA_W   = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       inst_id,
  input  logic              valid_id,
  input  logic              flush,
  input  logic              hold,
  input  logic              RegWrite_wb,
  input  logic [RA_W-1:0]   RegWriteAddr_wb,
  input  logic [DATA_W-1:0] RegWriteData_wb,
  output logic              stall_o,
  output logic              ex_valid,
  output logic              ex_RegWrite,
  output logic              ex_RegDst,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_ALUSrcB,
  output logic              ex_Branch,
  output logic [1:0]        ex_MemtoReg,
  output logic [3:0]        ex_ALUCode,
  output logic [DATA_W-1:0] ex_Imm,
  output logic [DATA_W-1:0] ex_RsData,
  output logic [DATA_W-1:0] ex_RtData,
  output logic [RA_W-1:0]   ex_RsAddr,
  output logic [RA_W-1:0]   ex_RtAddr,
  output logic [RA_W-1:0]   ex_RdAddr,
  output logic [4:0]        ex_shamt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [RA_W-1:0]   rs, rt, rd;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rs_data, rt_data;
  ctrl_t             id_ctrl, ex_ctrl;
  logic              luh;
  logic              refresh;

  assign rs    = inst_id[RS_LO +: RA_W];
  assign rt    = inst_id[RT_LO +: RA_W];
  assign rd    = inst_id[RD_LO +: RA_W];
  assign shamt = inst_id[SH_LO +: 5];
  assign imm   = DATA_W'($signed(inst_id[IMM_LO +: 16]));

  CtrlUnit u_ctrl (
    .op       (inst_id[OP_LO +: 6]),
    .funct    (inst_id[FN_LO +: 6]),
    .RegWrite (id_ctrl.RegWrite),
    .RegDst   (id_ctrl.RegDst),
    .MemRead  (id_ctrl.MemRead),
    .MemWrite (id_ctrl.MemWrite),
    .ALUSrcB  (id_ctrl.ALUSrcB),
    .Branch   (id_ctrl.Branch),
    .MemtoReg (id_ctrl.MemtoReg),
    .ALUCode  (id_ctrl.ALUCode)
  );

  regfile_bypass #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (RegWrite_wb),
    .waddr   (RegWriteAddr_wb),
    .wdata   (RegWriteData_wb),
    .raddr_a (rs),
    .rdata_a (rs_data),
    .raddr_b (rt),
    .rdata_b (rt_data)
  );

  // Load-use detection; rt is compared even for instructions that do not read it.
  always_comb begin
    luh = valid_id && ex_valid && ex_ctrl.MemRead && (ex_RtAddr != '0) &&
          ((ex_RtAddr == rs) || (ex_RtAddr == rt));
    stall_o = !flush && (hold || luh);
  end

  assign refresh = ex_valid && RegWrite_wb && (RegWriteAddr_wb != '0);

  // ID/EX register: flush > hold (with operand refresh) > load-use bubble > load.
  // Data fields are left untouched on flush/bubble since only valid/control matter there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_Imm    <= '0;
      ex_RsData <= '0;
      ex_RtData <= '0;
      ex_RsAddr <= '0;
      ex_RtAddr <= '0;
      ex_RdAddr <= '0;
      ex_shamt  <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (hold) begin
      if (refresh && (RegWriteAddr_wb == ex_RsAddr)) ex_RsData <= RegWriteData_wb;
      if (refresh && (RegWriteAddr_wb == ex_RtAddr)) ex_RtData <= RegWriteData_wb;
    end else if (luh) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid  <= valid_id;
      ex_ctrl   <= valid_id ? id_ctrl : '0;
      ex_Imm    <= imm;
      ex_RsData <= rs_data;
      ex_RtData <= rt_data;
      ex_RsAddr <= rs;
      ex_RtAddr <= rt;
      ex_RdAddr <= rd;
      ex_shamt  <= shamt;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_o && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ex_RegWrite = ex_ctrl.RegWrite;
  assign ex_RegDst   = ex_ctrl.RegDst;
  assign ex_MemRead  = ex_ctrl.MemRead;
  assign ex_MemWrite = ex_ctrl.MemWrite;
  assign ex_ALUSrcB  = ex_ctrl.ALUSrcB;
  assign ex_Branch   = ex_ctrl.Branch;
  assign ex_MemtoReg = ex_ctrl.MemtoReg;
  assign ex_ALUCode  = ex_ctrl.ALUCode;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (default and 64-bit/16-reg/2-bit-counter builds).
module tb_id_stage_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default build
  logic [31:0] inst_id;
  logic        valid_id, flush, hold, RegWrite_wb;
  logic [4:0]  RegWriteAddr_wb;
  logic [31:0] RegWriteData_wb;
  logic        stall_o, ex_valid, ex_RegWrite, ex_RegDst, ex_MemRead, ex_MemWrite, ex_ALUSrcB, ex_Branch;
  logic [1:0]  ex_MemtoReg;
  logic [3:0]  ex_ALUCode;
  logic [31:0] ex_Imm, ex_RsData, ex_RtData;
  logic [4:0]  ex_RsAddr, ex_RtAddr, ex_RdAddr, ex_shamt;
  logic [15:0] stall_cnt;

  // Wide build: DATA_W=64, REG_N=16, CNT_W=2
  logic [31:0] d2_inst;
  logic        d2_valid, d2_flush, d2_hold, d2_we;
  logic [3:0]  d2_waddr;
  logic [63:0] d2_wdata;
  logic        d2_stall, d2_ex_valid, d2_RegWrite, d2_RegDst, d2_MemRead, d2_MemWrite, d2_ALUSrcB, d2_Branch;
  logic [1:0]  d2_MemtoReg;
  logic [3:0]  d2_ALUCode;
  logic [63:0] d2_Imm, d2_RsData, d2_RtData;
  logic [3:0]  d2_RsAddr, d2_RtAddr, d2_RdAddr;
  logic [4:0]  d2_shamt;
  logic [1:0]  d2_stall_cnt;

  id_stage_pipe dut (
    .clk(clk), .reset(reset), .inst_id(inst_id), .valid_id(valid_id), .flush(flush), .hold(hold),
    .RegWrite_wb(RegWrite_wb), .RegWriteAddr_wb(RegWriteAddr_wb), .RegWriteData_wb(RegWriteData_wb),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_RegDst(ex_RegDst),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_ALUSrcB(ex_ALUSrcB), .ex_Branch(ex_Branch),
    .ex_MemtoReg(ex_MemtoReg), .ex_ALUCode(ex_ALUCode), .ex_Imm(ex_Imm), .ex_RsData(ex_RsData),
    .ex_RtData(ex_RtData), .ex_RsAddr(ex_RsAddr), .ex_RtAddr(ex_RtAddr), .ex_RdAddr(ex_RdAddr),
    .ex_shamt(ex_shamt), .stall_cnt(stall_cnt)
  );

  id_stage_pipe #(.DATA_W(64), .REG_N(16), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .inst_id(d2_inst), .valid_id(d2_valid), .flush(d2_flush), .hold(d2_hold),
    .RegWrite_wb(d2_we), .RegWriteAddr_wb(d2_waddr), .RegWriteData_wb(d2_wdata),
    .stall_o(d2_stall), .ex_valid(d2_ex_valid), .ex_RegWrite(d2_RegWrite), .ex_RegDst(d2_RegDst),
    .ex_MemRead(d2_MemRead), .ex_MemWrite(d2_MemWrite), .ex_ALUSrcB(d2_ALUSrcB), .ex_Branch(d2_Branch),
    .ex_MemtoReg(d2_MemtoReg), .ex_ALUCode(d2_ALUCode), .ex_Imm(d2_Imm), .ex_RsData(d2_RsData),
    .ex_RtData(d2_RtData), .ex_RsAddr(d2_RsAddr), .ex_RtAddr(d2_RtAddr), .ex_RdAddr(d2_RdAddr),
    .ex_shamt(d2_shamt), .stall_cnt(d2_stall_cnt)
  );

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {6'h08, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {6'h23, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst_id = '0; valid_id = 1'b0; flush = 1'b0; hold = 1'b0;
    RegWrite_wb = 1'b0; RegWriteAddr_wb = '0; RegWriteData_wb = '0;
    d2_inst = '0; d2_valid = 1'b0; d2_flush = 1'b0; d2_hold = 1'b0;
    d2_we = 1'b0; d2_waddr = '0; d2_wdata = '0;
    tick(); tick();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%0h exp=0", ex_valid); end
    checks++; if (ex_RegWrite !== 1'b0) begin failures++; $display("FAIL reset_ex_RegWrite got=%0h exp=0", ex_RegWrite); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0h exp=0", stall_cnt); end
    checks++; if (ex_RsData !== 32'd0) begin failures++; $display("FAIL reset_ex_RsData got=%0h exp=0", ex_RsData); end
    reset = 1'b0;
  endtask

  task automatic test_bypass();
    RegWrite_wb = 1'b1; RegWriteAddr_wb = 5'd5; RegWriteData_wb = 32'h1234_5678;
    inst_id = enc_add(5'd3, 5'd5, 5'd0); valid_id = 1'b1;
    tick();
    RegWrite_wb = 1'b0;
    checks++; if (ex_RsData !== 32'h1234_5678) begin failures++; $display("FAIL bypass_rsdata got=%0h exp=12345678", ex_RsData); end
    checks++; if (ex_RtData !== 32'd0) begin failures++; $display("FAIL bypass_rtdata got=%0h exp=0", ex_RtData); end
    checks++; if (ex_valid !== 1'b1 || ex_RegWrite !== 1'b1 || ex_RegDst !== 1'b1)
      begin failures++; $display("FAIL bypass_ctrl got=%0b%0b%0b exp=111", ex_valid, ex_RegWrite, ex_RegDst); end
    checks++; if (ex_RdAddr !== 5'd3 || ex_RsAddr !== 5'd5) begin failures++; $display("FAIL bypass_addr got=%0d/%0d exp=3/5", ex_RdAddr, ex_RsAddr); end
    inst_id = enc_add(5'd6, 5'd5, 5'd5);
    tick();
    checks++; if (ex_RsData !== 32'h1234_5678 || ex_RtData !== 32'h1234_5678)
      begin failures++; $display("FAIL stored_r5 got=%0h/%0h exp=12345678", ex_RsData, ex_RtData); end
  endtask

  task automatic test_load_use();
    inst_id = enc_lw(5'd2, 5'd1, 16'd0);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL lu_nostall_pre got=%0b exp=0", stall_o); end
    tick();
    checks++; if (ex_MemRead !== 1'b1 || ex_RtAddr !== 5'd2 || ex_MemtoReg !== 2'd1)
      begin failures++; $display("FAIL lu_load_in_ex got=%0b/%0d/%0d exp=1/2/1", ex_MemRead, ex_RtAddr, ex_MemtoReg); end
    inst_id = enc_add(5'd4, 5'd2, 5'd2);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", stall_o); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || ex_MemRead !== 1'b0)
      begin failures++; $display("FAIL lu_bubble got=%0b%0b%0b exp=000", ex_valid, ex_RegWrite, ex_MemRead); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL lu_one_cycle got=%0b exp=0", stall_o); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_RdAddr !== 5'd4 || ex_RsAddr !== 5'd2 || ex_RegWrite !== 1'b1)
      begin failures++; $display("FAIL lu_add_in_ex got=%0b/%0d/%0d/%0b exp=1/4/2/1", ex_valid, ex_RdAddr, ex_RsAddr, ex_RegWrite); end
  endtask

  task automatic test_flush_priority();
    inst_id = enc_lw(5'd2, 5'd1, 16'd0);
    tick();
    inst_id = enc_add(5'd4, 5'd2, 5'd2); hold = 1'b1; flush = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0b exp=0", stall_o); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_MemRead !== 1'b0) begin failures++; $display("FAIL flush_kill got=%0b%0b exp=00", ex_valid, ex_MemRead); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", stall_cnt); end
    flush = 1'b0; hold = 1'b0;
    tick();
  endtask

  task automatic test_hold_refresh();
    inst_id = enc_add(5'd3, 5'd7, 5'd0);
    tick();
    checks++; if (ex_RsAddr !== 5'd7 || ex_RsData !== 32'd0) begin failures++; $display("FAIL hold_setup got=%0d/%0h exp=7/0", ex_RsAddr, ex_RsData); end
    hold = 1'b1; inst_id = enc_addi(5'd9, 5'd0, 16'd5);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL hold_stall got=%0b exp=1", stall_o); end
    tick();
    RegWrite_wb = 1'b1; RegWriteAddr_wb = 5'd7; RegWriteData_wb = 32'h0000_AAAA;
    tick();
    RegWrite_wb = 1'b0;
    tick();
    hold = 1'b0;
    #1;
    checks++; if (ex_RsData !== 32'h0000_AAAA) begin failures++; $display("FAIL hold_refresh got=%0h exp=aaaa", ex_RsData); end
    checks++; if (ex_RtData !== 32'd0 || ex_RdAddr !== 5'd3 || ex_RtAddr !== 5'd0 || ex_RsAddr !== 5'd7)
      begin failures++; $display("FAIL hold_fields got=%0h/%0d/%0d/%0d exp=0/3/0/7", ex_RtData, ex_RdAddr, ex_RtAddr, ex_RsAddr); end
    checks++; if (ex_valid !== 1'b1 || ex_RegWrite !== 1'b1 || ex_ALUSrcB !== 1'b0 || ex_ALUCode !== 4'd0)
      begin failures++; $display("FAIL hold_ctrl got=%0b%0b%0b/%0d exp=110/0", ex_valid, ex_RegWrite, ex_ALUSrcB, ex_ALUCode); end
    checks++; if (stall_cnt !== 16'd4) begin failures++; $display("FAIL hold_cnt got=%0d exp=4", stall_cnt); end
    tick();
    checks++; if (ex_Imm !== 32'd5 || ex_ALUSrcB !== 1'b1 || ex_RegDst !== 1'b0 || ex_RtAddr !== 5'd9)
      begin failures++; $display("FAIL addi_decode got=%0h/%0b/%0b/%0d exp=5/1/0/9", ex_Imm, ex_ALUSrcB, ex_RegDst, ex_RtAddr); end
    inst_id = enc_addi(5'd9, 5'd7, 16'hFFFF);
    tick();
    checks++; if (ex_RsData !== 32'h0000_AAAA || ex_Imm !== 32'hFFFF_FFFF)
      begin failures++; $display("FAIL addi_neg got=%0h/%0h exp=aaaa/ffffffff", ex_RsData, ex_Imm); end
  endtask

  task automatic test_r0();
    RegWrite_wb = 1'b1; RegWriteAddr_wb = 5'd0; RegWriteData_wb = 32'h0000_FFFF;
    inst_id = enc_add(5'd1, 5'd0, 5'd0);
    tick();
    RegWrite_wb = 1'b0;
    checks++; if (ex_RsData !== 32'd0) begin failures++; $display("FAIL r0_bypass got=%0h exp=0", ex_RsData); end
    tick();
    checks++; if (ex_RsData !== 32'd0 || ex_RtData !== 32'd0) begin failures++; $display("FAIL r0_stored got=%0h/%0h exp=0", ex_RsData, ex_RtData); end
  endtask

  task automatic test_valid0();
    valid_id = 1'b0; inst_id = enc_add(5'd1, 5'd2, 5'd3);
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || ex_RegDst !== 1'b0)
      begin failures++; $display("FAIL invalid_ctrl got=%0b%0b%0b exp=000", ex_valid, ex_RegWrite, ex_RegDst); end
    valid_id = 1'b1; inst_id = enc_lw(5'd2, 5'd1, 16'd0);
    tick();
    valid_id = 1'b0; inst_id = enc_add(5'd4, 5'd2, 5'd2);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL invalid_no_luh got=%0b exp=0", stall_o); end
    tick();
  endtask

  task automatic test_luh_corners();
    valid_id = 1'b1; inst_id = enc_lw(5'd0, 5'd1, 16'd0);
    tick();
    inst_id = enc_add(5'd4, 5'd0, 5'd0);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL luh_r0_dest got=%0b exp=0", stall_o); end
    inst_id = enc_lw(5'd2, 5'd1, 16'd0);
    tick();
    inst_id = enc_addi(5'd2, 5'd1, 16'd1);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL luh_rt_conservative got=%0b exp=1", stall_o); end
    tick();
    checks++; if (stall_cnt !== 16'd5 || ex_valid !== 1'b0) begin failures++; $display("FAIL luh_rt_bubble got=%0d/%0b exp=5/0", stall_cnt, ex_valid); end
    valid_id = 1'b0;
  endtask

  task automatic test_params();
    d2_we = 1'b1; d2_waddr = 4'd3; d2_wdata = 64'h0123_4567_89AB_CDEF;
    tick();
    d2_we = 1'b0;
    d2_inst = {6'h08, 5'b10011, 5'd0, 16'h8000}; d2_valid = 1'b1;
    tick();
    checks++; if (d2_RsAddr !== 4'd3) begin failures++; $display("FAIL p_rsaddr got=%0d exp=3", d2_RsAddr); end
    checks++; if (d2_RsData !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL p_rsdata got=%0h exp=123456789abcdef", d2_RsData); end
    checks++; if (d2_Imm !== 64'hFFFF_FFFF_FFFF_8000) begin failures++; $display("FAIL p_imm got=%0h exp=ffffffffffff8000", d2_Imm); end
    d2_valid = 1'b0; d2_hold = 1'b1;
    tick(); tick();
    checks++; if (d2_stall_cnt !== 2'd2) begin failures++; $display("FAIL p_cnt2 got=%0d exp=2", d2_stall_cnt); end
    tick(); tick(); tick();
    checks++; if (d2_stall_cnt !== 2'd3) begin failures++; $display("FAIL p_saturate got=%0d exp=3", d2_stall_cnt); end
    d2_hold = 1'b0;
  endtask

  task automatic test_async_reset();
    valid_id = 1'b1; inst_id = enc_addi(5'd3, 5'd5, 16'h1234);
    tick();
    checks++; if (ex_RsData !== 32'h1234_5678 || ex_Imm !== 32'h0000_1234)
      begin failures++; $display("FAIL pre_reset got=%0h/%0h exp=12345678/1234", ex_RsData, ex_Imm); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || ex_ALUSrcB !== 1'b0)
      begin failures++; $display("FAIL areset_ctrl got=%0b%0b%0b exp=000", ex_valid, ex_RegWrite, ex_ALUSrcB); end
    checks++; if (ex_RsData !== 32'd0 || ex_Imm !== 32'd0 || ex_RdAddr !== 5'd0 || ex_RsAddr !== 5'd0)
      begin failures++; $display("FAIL areset_data got=%0h/%0h/%0d/%0d exp=0", ex_RsData, ex_Imm, ex_RdAddr, ex_RsAddr); end
    checks++; if (stall_cnt !== 16'd0 || d2_stall_cnt !== 2'd0)
      begin failures++; $display("FAIL areset_cnt got=%0d/%0d exp=0/0", stall_cnt, d2_stall_cnt); end
    tick();
    reset = 1'b0;
    inst_id = enc_add(5'd3, 5'd5, 5'd0);
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_RdAddr !== 5'd3 || ex_RsData !== 32'd0)
      begin failures++; $display("FAIL post_reset got=%0b/%0d/%0h exp=1/3/0", ex_valid, ex_RdAddr, ex_RsData); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_flush_priority();
    test_hold_refresh();
    test_r0();
    test_valid0();
    test_luh_corners();
    test_params();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
